// File: rtl/rng_share_ctrl_if.sv
// Bus interface for rng_share_ctrl.
// It bundles the reseed inputs, the request/grant handshake, the delivered random value
// and the status outputs. The requesters and the seed switches sit on the master side,
// and the controller sits on the slave side.
interface rng_share_ctrl_if #(
  parameter int NREQ = 4
);
  logic            seed_load;
  logic [7:0]      seed;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            rnd_valid;
  logic [7:0]      rnd_data;
  logic [7:0]      lfsr_q;
  logic            busy;

  modport master (
    output seed_load, seed, req,
    input  gnt, rnd_valid, rnd_data, lfsr_q, busy
  );

  modport slave (
    input  seed_load, seed, req,
    output gnt, rnd_valid, rnd_data, lfsr_q, busy
  );
endinterface

// File: rtl/rng_share_ctrl.sv
// rng_share_ctrl: shares one 8-bit Fibonacci LFSR between NREQ requesters.
// The LFSR steps once every DIV clocks. Requesters are served round-robin.
// Each grant delivers the value produced by the step that follows the grant,
// so two deliveries never carry the same step.
// The live LFSR state is exported for the seven-segment digit drivers.
// Optional build macro LFSR_ZERO_GUARD_EN stops the LFSR from sticking at zero.
// When it is defined, a tick at zero loads 8'h01, and a zero seed also loads 8'h01.
module rng_share_ctrl #(
  parameter int          NREQ     = 4,
  parameter int          DIV      = 500,
  parameter logic [7:0]  SEED_RST = 8'hA5
) (
  input  logic           clk,
  input  logic           reset,
  rng_share_ctrl_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_STEP = 2'd1,
    DELIVER   = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [7:0]      q;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   sel;
  logic [NREQ-1:0] gnt;
  logic            rnd_valid;
  logic [7:0]      rnd_data;
  logic            busy;

  logic            tick;
  logic [7:0]      tick_val;
  logic [7:0]      seed_val;
  logic [PW:0]     pick;

  // Advance the Fibonacci register one position. The feedback uses taps 0, 2, 3 and 4.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[4], v[7:1]};
  endfunction

  // Round-robin search. It returns {found, index} for the first set request after p, wrapping modulo NREQ.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW:0]   res;
    logic [PW-1:0] idx;
    res = {(PW+1){1'b0}};
    // Walk from the farthest candidate to the nearest, so the nearest hit is written last.
    for (int i = NREQ; i >= 1; i--) begin
      idx = PW'((int'(p) + i) % NREQ);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign tick = (count == CW'(DIV - 1));
  assign pick = rr_pick(bus.req, ptr);

  // Compute the value a tick loads and the value a reseed loads, including the zero guard when it is built in.
  always_comb begin
    tick_val = lfsr_step(q);
    seed_val = bus.seed;
`ifdef LFSR_ZERO_GUARD_EN
    if (q == 8'h00) begin
      tick_val = 8'h01;
    end else begin
      tick_val = lfsr_step(q);
    end
    if (bus.seed == 8'h00) begin
      seed_val = 8'h01;
    end else begin
      seed_val = bus.seed;
    end
`endif
  end

  // Step pacer and free-running LFSR. A reseed takes priority over a tick in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= {CW{1'b0}};
      q     <= SEED_RST;
    end else if (bus.seed_load) begin
      count <= {CW{1'b0}};
      q     <= seed_val;
    end else if (tick) begin
      count <= {CW{1'b0}};
      q     <= tick_val;
    end else begin
      count <= count + CW'(1);
    end
  end

  // Grant FSM with registered outputs. The delivery strobes are valid for exactly the one cycle spent in DELIVER.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= PW'(NREQ - 1);
      sel       <= {PW{1'b0}};
      gnt       <= {NREQ{1'b0}};
      rnd_valid <= 1'b0;
      rnd_data  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      gnt       <= {NREQ{1'b0}};
      rnd_valid <= 1'b0;
      if (bus.seed_load) begin
        // A pending grant is abandoned. The pointer is left untouched, so fairness is unchanged.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pick[PW]) begin
              sel   <= pick[PW-1:0];
              state <= WAIT_STEP;
              busy  <= 1'b1;
            end else begin
              busy  <= 1'b0;
            end
          end
          WAIT_STEP: begin
            if (!bus.req[sel]) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (tick) begin
              // Deliver the value that this same edge loads into the LFSR.
              state     <= DELIVER;
              gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
              rnd_valid <= 1'b1;
              rnd_data  <= tick_val;
              busy      <= 1'b1;
            end else begin
              busy  <= 1'b1;
            end
          end
          DELIVER: begin
            ptr   <= sel;
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.gnt       = gnt;
  assign bus.rnd_valid = rnd_valid;
  assign bus.rnd_data  = rnd_data;
  assign bus.lfsr_q    = q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Testbench for rng_share_ctrl.
// It runs three instances: DIV=4, DIV=1 with a zero reset seed, and DIV=8.
// Expected deliveries are pushed into per-instance queues by the stimulus process,
// and a negedge monitor pops and compares them. Define LFSR_ZERO_GUARD_EN to regress the guarded build.
module tb_rng_share_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rng_share_ctrl_if #(.NREQ(4)) bus4 ();
  rng_share_ctrl_if #(.NREQ(4)) bus1 ();
  rng_share_ctrl_if #(.NREQ(4)) bus8 ();

  rng_share_ctrl #(.NREQ(4), .DIV(4), .SEED_RST(8'hA5)) u4 (.clk(clk), .reset(reset), .bus(bus4));
  rng_share_ctrl #(.NREQ(4), .DIV(1), .SEED_RST(8'h00)) u1 (.clk(clk), .reset(reset), .bus(bus1));
  rng_share_ctrl #(.NREQ(4), .DIV(8), .SEED_RST(8'hA5)) u8 (.clk(clk), .reset(reset), .bus(bus8));

  int errors = 0;
  int checks = 0;

  logic [11:0] q4[$];
  logic [11:0] q1[$];
  logic [11:0] q8[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_model(input logic [7:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[4], v[7:1]};
  endfunction

  // Monitor: compare each delivery against the queue head; a grant outside a delivery is an error.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus4.rnd_valid) begin
        if (q4.size() == 0) check("u4 spurious valid", {31'd0, bus4.rnd_valid}, 32'd0);
        else check("u4 delivery", {20'd0, bus4.gnt, bus4.rnd_data}, {20'd0, q4.pop_front()});
      end else begin
        check("u4 idle gnt", {28'd0, bus4.gnt}, 32'd0);
      end
      if (bus1.rnd_valid) begin
        if (q1.size() == 0) check("u1 spurious valid", {31'd0, bus1.rnd_valid}, 32'd0);
        else check("u1 delivery", {20'd0, bus1.gnt, bus1.rnd_data}, {20'd0, q1.pop_front()});
      end else begin
        check("u1 idle gnt", {28'd0, bus1.gnt}, 32'd0);
      end
      if (bus8.rnd_valid) begin
        if (q8.size() == 0) check("u8 spurious valid", {31'd0, bus8.rnd_valid}, 32'd0);
        else check("u8 delivery", {20'd0, bus8.gnt, bus8.rnd_data}, {20'd0, q8.pop_front()});
      end else begin
        check("u8 idle gnt", {28'd0, bus8.gnt}, 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus4.seed_load = 1'b0; bus4.seed = 8'h00; bus4.req = 4'b0000;
    bus1.seed_load = 1'b0; bus1.seed = 8'h00; bus1.req = 4'b0000;
    bus8.seed_load = 1'b0; bus8.seed = 8'h00; bus8.req = 4'b0000;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] s;
    logic [3:0] g;

    // Reset state and free-running LFSR with no requests.
    do_reset();
    check("reset lfsr_q", {24'd0, bus4.lfsr_q}, 32'h0000_00A5);
    check("reset rnd_valid", {31'd0, bus4.rnd_valid}, 32'd0);
    check("reset rnd_data", {24'd0, bus4.rnd_data}, 32'd0);
    check("reset busy", {31'd0, bus4.busy}, 32'd0);
    check("reset lfsr_q zero seed", {24'd0, bus1.lfsr_q}, 32'd0);
    step(1);
`ifdef LFSR_ZERO_GUARD_EN
    check("zero tick guard", {24'd0, bus1.lfsr_q}, 32'h0000_0001);
`else
    check("zero tick stuck", {24'd0, bus1.lfsr_q}, 32'd0);
`endif
    step(3);
    check("lfsr after 4", {24'd0, bus4.lfsr_q}, 32'h0000_0052);
    step(4);
    check("lfsr after 8", {24'd0, bus4.lfsr_q}, 32'h0000_00A9);
    check("idle busy", {31'd0, bus4.busy}, 32'd0);

    // Single requester held from reset release on DIV=4.
    do_reset();
    bus4.req = 4'b0001;
    q4.push_back({4'b0001, 8'h52});
    q4.push_back({4'b0001, 8'hA9});
    step(2);
    check("u4 busy in wait", {31'd0, bus4.busy}, 32'd1);
    step(6);
    bus4.req = 4'b0000;
    step(2);

    // Round robin on DIV=1 after reseeding to A5. Deliveries land 2,5,8,11,14 steps after the seed.
    do_reset();
    bus1.seed_load = 1'b1;
    bus1.seed = 8'hA5;
    step(1);
    check("u1 reseed", {24'd0, bus1.lfsr_q}, 32'h0000_00A5);
    bus1.seed_load = 1'b0;
    bus1.req = 4'b1111;
    s = 8'hA5;
    g = 4'b0001;
    for (int k = 1; k <= 14; k++) begin
      s = lfsr_model(s);
      if (k % 3 == 2) begin
        q1.push_back({g, s});
        g = {g[2:0], g[3]};
      end
    end
    step(14);
    bus1.req = 4'b0000;
    step(3);

    // Request dropped during WAIT_STEP on DIV=8. The pointer must not move.
    do_reset();
    bus8.req = 4'b0100;
    step(2);
    check("u8 busy in wait", {31'd0, bus8.busy}, 32'd1);
    bus8.req = 4'b0000;
    step(1);
    check("u8 busy after drop", {31'd0, bus8.busy}, 32'd0);
    step(1);
    bus8.req = 4'b1100;
    q8.push_back({4'b0100, 8'h52});
    q8.push_back({4'b1000, 8'hA9});
    step(12);
    bus8.req = 4'b0000;
    step(2);

    // Reseed to 3C on the tick edge while in WAIT_STEP. The next tick gives 9E.
    do_reset();
    bus4.req = 4'b0001;
    step(3);
    bus4.seed_load = 1'b1;
    bus4.seed = 8'h3C;
    step(1);
    check("seed over tick lfsr", {24'd0, bus4.lfsr_q}, 32'h0000_003C);
    check("seed over tick busy", {31'd0, bus4.busy}, 32'd0);
    check("seed over tick valid", {31'd0, bus4.rnd_valid}, 32'd0);
    bus4.seed_load = 1'b0;
    q4.push_back({4'b0001, 8'h9E});
    step(3);
    check("count restarted", {24'd0, bus4.lfsr_q}, 32'h0000_003C);
    step(1);
    check("step from 3C", {24'd0, bus4.lfsr_q}, 32'h0000_009E);
    bus4.req = 4'b0000;
    step(2);

    // Zero seed.
    do_reset();
    bus4.seed_load = 1'b1;
    bus4.seed = 8'h00;
    step(1);
    bus4.seed_load = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
    check("zero seed load", {24'd0, bus4.lfsr_q}, 32'h0000_0001);
    step(4);
    check("zero seed tick1", {24'd0, bus4.lfsr_q}, 32'h0000_0080);
    step(4);
    check("zero seed tick2", {24'd0, bus4.lfsr_q}, 32'h0000_0040);
`else
    check("zero seed load", {24'd0, bus4.lfsr_q}, 32'd0);
    step(4);
    check("zero seed tick1", {24'd0, bus4.lfsr_q}, 32'd0);
    step(4);
    check("zero seed tick2", {24'd0, bus4.lfsr_q}, 32'd0);
`endif

    step(2);
    check("u4 queue drained", q4.size(), 32'd0);
    check("u1 queue drained", q1.size(), 32'd0);
    check("u8 queue drained", q8.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
